hazard_stall_unit: RTL and testbench

- Interlock controller for the 16-bit A/B-register pipeline. It covers the hazards the forwarding unit cannot resolve.
- Watches the IF/ID instruction and keeps its own shadow copy of the EX and MEM stage classes.
- Issues PC/IF-ID stalls, ID/EX bubbles, IF/ID flushes and a whole-pipeline freeze.
- Sits beside the forwarding unit in the ID stage; its outputs drive the stage-register enables and clears.

---
 rtl/hazard_pkg.sv | 30 +++
 rtl/hazard_opclass.sv | 24 ++
 rtl/hazard_stall_unit.sv | 122 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode constants, per-instruction hazard class and FSM state type
// for the A/B-register pipeline interlock.
package hazard_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_LDA  = 6'h01;
  localparam logic [5:0] OP_LDB  = 6'h02;
  localparam logic [5:0] OP_STA  = 6'h03;
  localparam logic [5:0] OP_ADDA = 6'h04;
  localparam logic [5:0] OP_ADDB = 6'h05;
  localparam logic [5:0] OP_BAZ  = 6'h06;

  typedef struct packed {
    logic valid;
    logic wrA;
    logic wrB;
    logic rdA;
    logic rdB;
    logic isLoad;
    logic isMem;
  } opClassT;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } stallStateT;

  localparam opClassT NOP_CLASS = '0;

endpackage

// File: rtl/hazard_opclass.sv
// Combinational opcode-to-class decoder; unknown opcodes decode as NOP.
module hazard_opclass
  import hazard_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  output opClassT             opClass
);

  always_comb begin
    opClass = NOP_CLASS;
    case (opcode)
      OPCODE_W'(OP_LDA):  opClass = '{valid: 1'b1, wrA: 1'b1, wrB: 1'b0, rdA: 1'b0, rdB: 1'b0, isLoad: 1'b1, isMem: 1'b0};
      OPCODE_W'(OP_LDB):  opClass = '{valid: 1'b1, wrA: 1'b0, wrB: 1'b1, rdA: 1'b0, rdB: 1'b0, isLoad: 1'b1, isMem: 1'b0};
      OPCODE_W'(OP_STA):  opClass = '{valid: 1'b1, wrA: 1'b0, wrB: 1'b0, rdA: 1'b1, rdB: 1'b0, isLoad: 1'b0, isMem: 1'b1};
      OPCODE_W'(OP_ADDA): opClass = '{valid: 1'b1, wrA: 1'b1, wrB: 1'b0, rdA: 1'b1, rdB: 1'b1, isLoad: 1'b0, isMem: 1'b0};
      OPCODE_W'(OP_ADDB): opClass = '{valid: 1'b1, wrA: 1'b0, wrB: 1'b1, rdA: 1'b1, rdB: 1'b1, isLoad: 1'b0, isMem: 1'b0};
      OPCODE_W'(OP_BAZ):  opClass = '{valid: 1'b1, wrA: 1'b0, wrB: 1'b0, rdA: 1'b1, rdB: 1'b0, isLoad: 1'b0, isMem: 1'b0};
      default:            opClass = NOP_CLASS;
    endcase
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: memory-wait freeze, taken-branch flush and load-use stall.
// Optional saturating stall counters are built when STALL_COUNTERS_EN is defined.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      iInstruction,
  input  logic             iBranchTaken,
  input  logic             iMemReady,
  output logic             oStallPC,
  output logic             oStallIFID,
  output logic             oBubbleIDEX,
  output logic             oFlushIFID,
  output logic             oFreeze,
  output logic             oMemTimeout,
  output logic [CNT_W-1:0] oLoadStalls,
  output logic [CNT_W-1:0] oMemStalls
);

  opClassT          idClass;
  opClassT          exQ;
  opClassT          memQ;
  stallStateT       stateQ;
  logic [CNT_W-1:0] waitCntQ;
  logic [CNT_W-1:0] waitCntNext;
  logic             timeoutQ;
  logic             timeoutHit;
  logic             freeze;
  logic             branch;
  logic             loadUse;
  logic             bubble;

  hazard_opclass #(.OPCODE_W(OPCODE_W)) idDecode (
    .opcode  (iInstruction[15 -: OPCODE_W]),
    .opClass (idClass)
  );

  // A taken branch is held off during a freeze because it stays parked in EX.
  assign freeze  = memQ.valid & memQ.isMem & ~iMemReady;
  assign branch  = ~freeze & iBranchTaken;
  assign loadUse = ~freeze & ~iBranchTaken & exQ.valid & exQ.isLoad & idClass.valid &
                   ((idClass.rdA & exQ.wrA) | (idClass.rdB & exQ.wrB));
  assign bubble  = branch | loadUse;

  always_comb begin
    waitCntNext = '0;
    if (freeze) begin
      if (stateQ == RUN)
        waitCntNext = CNT_W'(1);
      else if (waitCntQ != '1)
        waitCntNext = waitCntQ + CNT_W'(1);
      else
        waitCntNext = waitCntQ;
    end
  end

  assign timeoutHit = freeze & (waitCntNext > CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exQ  <= NOP_CLASS;
      memQ <= NOP_CLASS;
    end else if (!freeze) begin
      memQ <= exQ;
      exQ  <= bubble ? NOP_CLASS : idClass;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= RUN;
      waitCntQ <= '0;
      timeoutQ <= 1'b0;
    end else begin
      case (stateQ)
        RUN:      if (freeze) stateQ <= MEM_WAIT;
        MEM_WAIT: if (!freeze) stateQ <= RUN;
        default:  stateQ <= RUN;
      endcase
      waitCntQ <= waitCntNext;
      if (timeoutHit)
        timeoutQ <= 1'b1;
    end
  end

  // Stage-enable controls act in the same cycle, so they stay combinational.
  assign oFreeze     = rst_n & freeze;
  assign oFlushIFID  = rst_n & branch;
  assign oBubbleIDEX = rst_n & bubble;
  assign oStallPC    = rst_n & loadUse;
  assign oStallIFID  = rst_n & loadUse;
  assign oMemTimeout = rst_n & (timeoutQ | timeoutHit);

`ifdef STALL_COUNTERS_EN
  logic [CNT_W-1:0] loadStallsQ;
  logic [CNT_W-1:0] memStallsQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loadStallsQ <= '0;
      memStallsQ  <= '0;
    end else begin
      if (loadUse && loadStallsQ != '1)
        loadStallsQ <= loadStallsQ + CNT_W'(1);
      if (freeze && memStallsQ != '1)
        memStallsQ <= memStallsQ + CNT_W'(1);
    end
  end

  assign oLoadStalls = loadStallsQ;
  assign oMemStalls  = memStallsQ;
`else
  assign oLoadStalls = '0;
  assign oMemStalls  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with an opcode-level pipeline model
// checked every cycle plus hand-computed literal expectations.
module tb_hazard_stall_unit;

  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 16;

  localparam logic [5:0] NOP  = 6'h00;
  localparam logic [5:0] LDA  = 6'h01;
  localparam logic [5:0] LDB  = 6'h02;
  localparam logic [5:0] STA  = 6'h03;
  localparam logic [5:0] ADDA = 6'h04;
  localparam logic [5:0] ADDB = 6'h05;
  localparam logic [5:0] BAZ  = 6'h06;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      iInstruction = 16'h0000;
  logic             iBranchTaken = 1'b0;
  logic             iMemReady = 1'b1;
  logic             oStallPC, oStallIFID, oBubbleIDEX, oFlushIFID, oFreeze, oMemTimeout;
  logic [CNT_W-1:0] oLoadStalls, oMemStalls;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  hazard_stall_unit #(.OPCODE_W(6), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iInstruction (iInstruction),
    .iBranchTaken (iBranchTaken),
    .iMemReady    (iMemReady),
    .oStallPC     (oStallPC),
    .oStallIFID   (oStallIFID),
    .oBubbleIDEX  (oBubbleIDEX),
    .oFlushIFID   (oFlushIFID),
    .oFreeze      (oFreeze),
    .oMemTimeout  (oMemTimeout),
    .oLoadStalls  (oLoadStalls),
    .oMemStalls   (oMemStalls)
  );

  always #5 clk = ~clk;

  // ---------------- opcode-level model ----------------
  function automatic int normOp(input logic [15:0] ins);
    int op;
    op = int'(ins[15:10]);
    return (op >= 1 && op <= 6) ? op : 0;
  endfunction

  function automatic bit readsReg(input int op, input int r);  // r: 0=A, 1=B
    case (op)
      3, 6:    return r == 0;
      4, 5:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writesReg(input int op, input int r);
    case (op)
      1, 4:    return r == 0;
      2, 5:    return r == 1;
      default: return 1'b0;
    endcase
  endfunction

  // {stallPC, stallIFID, bubble, flush, freeze, timeout}
  function automatic logic [5:0] modelOut(input logic [15:0] ins, input logic br, input logic rdy,
                                          input logic rst, input int exOp, input int memOp,
                                          input int run, input bit sticky);
    int  id;
    bit  frz, lu, brf, to;
    id  = normOp(ins);
    frz = (memOp == 3) && !rdy;
    brf = !frz && br;
    lu  = !frz && !br && (exOp == 1 || exOp == 2) &&
          ((readsReg(id, 0) && writesReg(exOp, 0)) || (readsReg(id, 1) && writesReg(exOp, 1)));
    to  = sticky || (frz && (run + 1) > MAX_WAIT);
    if (!rst) return 6'b0;
    return {lu, lu, lu || brf, brf, frz, to};
  endfunction

  int mEx = 0, mMem = 0, mRun = 0, mLoadCnt = 0, mMemCnt = 0;
  bit mSticky = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    logic [5:0] o;
    if (!rst_n) begin
      mEx <= 0; mMem <= 0; mRun <= 0; mSticky <= 1'b0; mLoadCnt <= 0; mMemCnt <= 0;
    end else begin
      o = modelOut(iInstruction, iBranchTaken, iMemReady, rst_n, mEx, mMem, mRun, mSticky);
      mSticky <= o[0];
      if (o[1]) begin
        mRun    <= mRun + 1;
        mMemCnt <= mMemCnt + 1;
      end else begin
        mRun <= 0;
        mMem <= mEx;
        mEx  <= o[3] ? 0 : normOp(iInstruction);
      end
      if (o[5]) mLoadCnt <= mLoadCnt + 1;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp, act;
    logic [CNT_W-1:0] expLoad, expMem;
    cycle = cycle + 1;
    exp = modelOut(iInstruction, iBranchTaken, iMemReady, rst_n, mEx, mMem, mRun, mSticky);
    act = {oStallPC, oStallIFID, oBubbleIDEX, oFlushIFID, oFreeze, oMemTimeout};
`ifdef STALL_COUNTERS_EN
    expLoad = CNT_W'(mLoadCnt);
    expMem  = CNT_W'(mMemCnt);
`else
    expLoad = '0;
    expMem  = '0;
`endif
    checks = checks + 1;
    if (act !== exp || oLoadStalls !== expLoad || oMemStalls !== expMem) begin
      failures = failures + 1;
      $display("FAIL model cycle=%0d ctl actual=%b required=%b loadStalls actual=%0d required=%0d memStalls actual=%0d required=%0d",
               cycle, act, exp, oLoadStalls, expLoad, oMemStalls, expMem);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic [5:0] op, input logic br, input logic rdy);
    @(posedge clk);
    #1;
    iInstruction = {op, 10'h000};
    iBranchTaken = br;
    iMemReady    = rdy;
    @(negedge clk);
    #1;
    $display("cyc=%0d op=%0h br=%0b rdy=%0b -> stallPC=%0b stallIFID=%0b bubble=%0b flush=%0b freeze=%0b timeout=%0b",
             cycle, op, br, rdy, oStallPC, oStallIFID, oBubbleIDEX, oFlushIFID, oFreeze, oMemTimeout);
  endtask

  task automatic chkCtl(input string name, input logic [5:0] exp);
    chk(name, 16'({oStallPC, oStallIFID, oBubbleIDEX, oFlushIFID, oFreeze, oMemTimeout}), 16'(exp));
  endtask

  typedef struct {
    logic [5:0] first;
    logic [5:0] second;
    logic       stall;
  } pairT;

  pairT pairs[8] = '{
    '{LDA,  BAZ,   1'b1},
    '{LDA,  STA,   1'b1},
    '{LDB,  ADDB,  1'b1},
    '{LDB,  BAZ,   1'b0},
    '{LDA,  6'h3F, 1'b0},
    '{LDB,  ADDA,  1'b1},
    '{ADDA, ADDB,  1'b0},
    '{LDB,  STA,   1'b0}
  };

  initial begin
    #1;
    chkCtl("reset_outputs", 6'b000000);
    chk("reset_loadStalls", oLoadStalls, 16'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // LDA then ADDA: one-cycle load-use stall
    setIn(LDA, 1'b0, 1'b1);  chkCtl("lda_in_id", 6'b000000);
    setIn(ADDA, 1'b0, 1'b1); chkCtl("lda_adda_stall", 6'b111000);
    setIn(ADDA, 1'b0, 1'b1); chkCtl("lda_adda_released", 6'b000000);
`ifdef STALL_COUNTERS_EN
    chk("loadStalls_one", oLoadStalls, 16'd1);
`else
    chk("loadStalls_off", oLoadStalls, 16'd0);
`endif
    setIn(NOP, 1'b0, 1'b1);

    // LDB then STA: no dependency
    setIn(LDB, 1'b0, 1'b1);  chkCtl("ldb_in_id", 6'b000000);
    setIn(STA, 1'b0, 1'b1);  chkCtl("ldb_sta_nostall", 6'b000000);
    setIn(NOP, 1'b0, 1'b1);  chkCtl("ldb_sta_next", 6'b000000);
    setIn(NOP, 1'b0, 1'b1);

    // ADDA then ADDB: forwarding covers it
    setIn(ADDA, 1'b0, 1'b1);
    setIn(ADDB, 1'b0, 1'b1); chkCtl("adda_addb_nostall", 6'b000000);
    setIn(NOP, 1'b0, 1'b1);

    foreach (pairs[i]) begin
      setIn(pairs[i].first, 1'b0, 1'b1);
      setIn(pairs[i].second, 1'b0, 1'b1);
      chk($sformatf("pair%0d_stall", i), 16'({oStallPC, oBubbleIDEX}), 16'({2{pairs[i].stall}}));
      setIn(NOP, 1'b0, 1'b1);
      setIn(NOP, 1'b0, 1'b1);
    end

    // STA in MEM with memory not ready for 10 cycles; LDA held in EX behind it
    setIn(STA, 1'b0, 1'b1);
    setIn(LDA, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      setIn(ADDA, 1'b0, 1'b0);
      chkCtl($sformatf("freeze_k%0d", k), {5'b00001, (k >= 9) ? 1'b1 : 1'b0} << 0 | 6'b000010);
    end
    setIn(ADDA, 1'b0, 1'b1); chkCtl("post_freeze_loaduse", 6'b111001);
`ifdef STALL_COUNTERS_EN
    chk("memStalls_ten", oMemStalls, 16'd10);
`else
    chk("memStalls_off", oMemStalls, 16'd0);
`endif
    setIn(ADDA, 1'b0, 1'b1); chkCtl("post_freeze_clear", 6'b000001);
    setIn(NOP, 1'b0, 1'b1);

    // Taken branch overrides load-use
    setIn(LDA, 1'b0, 1'b1);
    setIn(ADDA, 1'b1, 1'b1); chkCtl("branch_over_loaduse", 6'b001101);
    setIn(NOP, 1'b0, 1'b1);  chkCtl("after_branch", 6'b000001);

    // Reset during a freeze (with a pending taken branch)
    setIn(STA, 1'b0, 1'b1);
    setIn(NOP, 1'b0, 1'b1);
    setIn(NOP, 1'b1, 1'b0);  chkCtl("freeze_holds_branch", 6'b000011);
    rst_n = 1'b0;
    #1 chkCtl("reset_mid_freeze", 6'b000000);
    setIn(NOP, 1'b1, 1'b0);  chkCtl("reset_held", 6'b000000);
    iBranchTaken = 1'b0;
    iMemReady = 1'b1;
    rst_n = 1'b1;
    #1 chkCtl("reset_release", 6'b000000);
    for (int k = 0; k < 3; k++) begin
      setIn(NOP, 1'b0, 1'b1);
      chkCtl("nop_stream", 6'b000000);
    end

    // Freeze of exactly MAX_WAIT cycles must not time out
    setIn(STA, 1'b0, 1'b1);
    setIn(NOP, 1'b0, 1'b1);
    for (int k = 1; k <= MAX_WAIT; k++) begin
      setIn(NOP, 1'b0, 1'b0);
      chkCtl("freeze_at_limit", 6'b000010);
    end
    setIn(NOP, 1'b0, 1'b1);  chkCtl("limit_no_timeout", 6'b000000);
    setIn(NOP, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
